// File: rtl/host_axi_pkg.sv
// Shared AXI encodings and bridge FSM state for the host<->AXI bridges.
package host_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    H2M_IDLE,
    H2M_ADDR,
    H2M_WAIT,
    H2M_RSP
  } h2m_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/host_to_maxi.sv
// LSU req/gnt/rvalid host port to single-beat AXI4 master, one access in flight.
// Latency (zero-wait slave): gnt c0, AR/AW c1, R/B c2, rvalid c3.
// Backpressure: gnt only in IDLE; AXI valids hold until handshake. HOST_TO_MAXI_ERR_CAPTURE_EN adds err_addr_o/err_cnt_o.
module host_to_maxi
  import host_axi_pkg::*;
#(
  parameter int AXI_ID_WIDTH = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int AXI_ID_VAL   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [31:0]             data_addr_i,
  input  logic                    data_we_i,
  input  logic [3:0]              data_be_i,
  input  logic [31:0]             data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic                    data_err_o,
  output logic [31:0]             data_rdata_o,
`ifdef HOST_TO_MAXI_ERR_CAPTURE_EN
  output logic [31:0]             err_addr_o,
  output logic [15:0]             err_cnt_o,
`endif
  output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_rid,
  input  logic [31:0]             m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [31:0]             m_axi_wdata,
  output logic [3:0]              m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  localparam logic [AXI_ID_WIDTH-1:0] ID = AXI_ID_WIDTH'(AXI_ID_VAL);

  h2m_state_e  state_q, state_d;
  logic [29:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        aw_done_q, w_done_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        rsp_hs, rsp_err;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^data_addr_i[1:0];

  always_comb begin
    state_d       = state_q;
    data_gnt_o    = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_bready  = 1'b0;
    case (state_q)
      H2M_IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i) state_d = H2M_ADDR;
      end
      H2M_ADDR: begin
        if (!we_q) begin
          m_axi_arvalid = 1'b1;
          if (m_axi_arready) state_d = H2M_WAIT;
        end else begin
          // AW and W retire independently; leave once both are done, in either order.
          m_axi_awvalid = !aw_done_q;
          m_axi_wvalid  = !w_done_q;
          if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready)) state_d = H2M_WAIT;
        end
      end
      H2M_WAIT: begin
        m_axi_rready = !we_q;
        m_axi_bready = we_q;
        if (we_q ? m_axi_bvalid : m_axi_rvalid) state_d = H2M_RSP;
      end
      H2M_RSP:  state_d = H2M_IDLE;
      default:  state_d = H2M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= H2M_IDLE;
    else     state_q <= state_d;
  end

  assign rsp_hs  = (m_axi_rready && m_axi_rvalid) || (m_axi_bready && m_axi_bvalid);
  assign rsp_err = we_q ? (resp_is_err(m_axi_bresp) || (m_axi_bid != ID))
                        : (resp_is_err(m_axi_rresp) || (m_axi_rid != ID) || !m_axi_rlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (data_gnt_o) begin
        addr_q    <= data_addr_i[31:2];
        we_q      <= data_we_i;
        be_q      <= data_be_i;
        wdata_q   <= data_wdata_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (m_axi_awvalid && m_axi_awready) aw_done_q <= 1'b1;
      if (m_axi_wvalid && m_axi_wready)   w_done_q  <= 1'b1;
      if (rsp_hs) begin
        rdata_q <= we_q ? 32'd0 : m_axi_rdata;
        err_q   <= rsp_err;
      end
    end
  end

`ifdef HOST_TO_MAXI_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else if (rsp_hs && rsp_err) begin
      err_addr_o <= {addr_q, 2'b00};
      if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

  assign data_rvalid_o = (state_q == H2M_RSP);
  assign data_err_o    = data_rvalid_o && err_q;
  assign data_rdata_o  = rdata_q;

  assign m_axi_arid    = ID;
  assign m_axi_araddr  = ADDR_WIDTH'({addr_q, 2'b00});
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = AXI_SIZE_4B;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_awid    = ID;
  assign m_axi_awaddr  = ADDR_WIDTH'({addr_q, 2'b00});
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = be_q;
  assign m_axi_wlast   = 1'b1;

endmodule

// File: tb/tb_host_to_maxi.sv
// Randomized bench for host_to_maxi: the bench acts as AXI slave and predicts each host response.
module tb_host_to_maxi;

  localparam logic [3:0] EXP_ID = 4'd5;
  localparam logic [3:0] BAD_ID = 4'd6;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;
`ifdef HOST_TO_MAXI_ERR_CAPTURE_EN
  logic [31:0] err_addr;
  logic [15:0] err_cnt;
`endif
  logic [3:0]  m_axi_arid, m_axi_rid, m_axi_awid, m_axi_bid;
  logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_rdata, m_axi_wdata;
  logic [7:0]  m_axi_arlen, m_axi_awlen;
  logic [2:0]  m_axi_arsize, m_axi_awsize;
  logic [1:0]  m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [3:0]  m_axi_wstrb;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [31:0] exp_eaddr = 32'd0;

  always #5 clk = ~clk;

  host_to_maxi #(.AXI_ID_WIDTH(4), .ADDR_WIDTH(32), .AXI_ID_VAL(5)) dut (
    .clk(clk), .rst(rst),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_err_o(data_err), .data_rdata_o(data_rdata),
`ifdef HOST_TO_MAXI_ERR_CAPTURE_EN
    .err_addr_o(err_addr), .err_cnt_o(err_cnt),
`endif
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_arready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid  = 1'b0; m_axi_bvalid  = 1'b0;
  endtask

  task automatic check_err_capture();
`ifdef HOST_TO_MAXI_ERR_CAPTURE_EN
    check("err_cnt", err_cnt, exp_cnt);
    check("err_addr", err_addr, exp_eaddr);
`endif
  endtask

  // Called at a negedge; returns at the negedge after the host response pulse.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int a_dly, input int w_dly, input int d_dly,
                         input logic [1:0] resp, input bit bad_id, input bit bad_last,
                         input bit keep_req, input int exp_lat);
    int cyc, a_hs, w_hs, d_hs, d_start, rsp_cyc;
    bit exp_err, d_vld;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    exp_err  = resp[1] | bad_id | (!we & bad_last);
    data_req = 1'b1; data_we = we; data_addr = addr; data_be = be; data_wdata = wd;
    #1 check("gnt_idle", data_gnt, 1);
    @(negedge clk);
    if (!keep_req) data_req = 1'b0;
    cyc = 1; a_hs = 0; w_hs = we ? 0 : 1; d_hs = 0; d_start = -1; rsp_cyc = -1;
    forever begin
      if (keep_req) check("gnt_busy", data_gnt, 0);
      if (data_rvalid) begin
        rsp_cyc = cyc;
        check("rsp_rdata", data_rdata, we ? 32'd0 : rd);
        check("rsp_err", data_err, exp_err);
      end
      if (we) begin
        check("ar_quiet", m_axi_arvalid, 0);
        check("rready_quiet", m_axi_rready, 0);
        if (d_start < 0) check("bready_early", m_axi_bready, 0);
        if (m_axi_awvalid)
          check("aw_fields", {m_axi_awaddr, m_axi_awid, m_axi_awlen, m_axi_awsize, m_axi_awburst},
                {exp_addr, EXP_ID, 8'd0, 3'b010, 2'b01});
        if (m_axi_wvalid) check("w_fields", {m_axi_wdata, m_axi_wstrb, m_axi_wlast}, {wd, be, 1'b1});
        m_axi_awready = (cyc > a_dly);
        m_axi_wready  = (cyc > w_dly);
        if (m_axi_awvalid && m_axi_awready) a_hs++;
        if (m_axi_wvalid && m_axi_wready) w_hs++;
      end else begin
        check("aw_w_quiet", {m_axi_awvalid, m_axi_wvalid}, 0);
        check("bready_quiet", m_axi_bready, 0);
        if (d_start < 0) check("rready_early", m_axi_rready, 0);
        if (m_axi_arvalid)
          check("ar_fields", {m_axi_araddr, m_axi_arid, m_axi_arlen, m_axi_arsize, m_axi_arburst},
                {exp_addr, EXP_ID, 8'd0, 3'b010, 2'b01});
        m_axi_arready = (cyc > a_dly);
        if (m_axi_arvalid && m_axi_arready) a_hs++;
      end
      if (d_start < 0 && a_hs > 0 && w_hs > 0) d_start = cyc;
      d_vld = (d_start >= 0) && (cyc > d_start + d_dly) && (d_hs == 0);
      if (we) begin
        m_axi_bvalid = d_vld; m_axi_bid = bad_id ? BAD_ID : EXP_ID; m_axi_bresp = resp;
        m_axi_rvalid = 1'($urandom_range(0, 1)); m_axi_rdata = $urandom;
        m_axi_rid = EXP_ID; m_axi_rresp = 2'b00; m_axi_rlast = 1'b1;
        if (d_vld && m_axi_bready) d_hs++;
      end else begin
        m_axi_rvalid = d_vld; m_axi_rid = bad_id ? BAD_ID : EXP_ID; m_axi_rresp = resp;
        m_axi_rdata = rd; m_axi_rlast = !bad_last;
        m_axi_bvalid = 1'($urandom_range(0, 1)); m_axi_bid = EXP_ID; m_axi_bresp = 2'b10;
        if (d_vld && m_axi_rready) d_hs++;
      end
      if (rsp_cyc >= 0 || cyc >= 80) break;
      @(negedge clk);
      cyc++;
    end
    check("rsp_seen", rsp_cyc >= 0, 1);
    if (exp_lat > 0) check("latency", rsp_cyc, exp_lat);
    slave_idle();
    if (exp_err) begin
      if (exp_cnt < 65535) exp_cnt++;
      exp_eaddr = exp_addr;
    end
    @(negedge clk);
    check("rvalid_pulse", data_rvalid, 0);
    check("addr_beats", a_hs, 1);
    if (we) check("w_beats", w_hs, 1);
    check("data_beats", d_hs, 1);
    check_err_capture();
  endtask

  initial begin
    rst = 1'b1; data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_be = '0; data_wdata = '0;
    slave_idle();
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
    m_axi_bid = '0; m_axi_bresp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready,
                       data_rvalid, data_err, data_gnt}, 0);
    check("rst_rdata", data_rdata, 0);
    check_err_capture();
    rst = 1'b0;
    @(negedge clk);

    // Stray R/B valids while idle must be ignored.
    m_axi_rvalid = 1'b1; m_axi_bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stray_rsp", {data_rvalid, m_axi_rready, m_axi_bready}, 0);
    end
    slave_idle();

    //     we  addr          be    wdata         rdata         aw w  d  resp   id lst keep lat
    run_txn(1, 32'h0000_1000, 4'hF, 32'hDEADBEEF, 32'h0,        3, 0, 0, 2'b00, 0, 0, 0, 0);
    run_txn(0, 32'h0000_2006, 4'hF, 32'h0,        32'hCAFEF00D, 0, 0, 2, 2'b00, 0, 0, 0, 0);
    run_txn(1, 32'h0000_3008, 4'h3, 32'h12345678, 32'h0,        0, 0, 0, 2'b10, 0, 0, 0, 0);
    run_txn(0, 32'h0000_4000, 4'hF, 32'h0,        32'h0BADCAFE, 0, 0, 0, 2'b00, 0, 0, 0, 3);
    run_txn(1, 32'h0000_5004, 4'h1, 32'hA5A5A5A5, 32'h0,        0, 0, 0, 2'b00, 0, 0, 0, 3);
    run_txn(1, 32'h0000_6000, 4'hC, 32'h11112222, 32'h0,        2, 0, 1, 2'b00, 0, 0, 0, 0);
    run_txn(1, 32'h0000_6004, 4'hF, 32'h33334444, 32'h0,        1, 1, 0, 2'b00, 0, 0, 0, 0);
    run_txn(1, 32'h0000_6008, 4'hF, 32'h55556666, 32'h0,        0, 3, 0, 2'b00, 0, 0, 0, 0);
    run_txn(0, 32'h0000_700C, 4'hF, 32'h0,        32'h77778888, 1, 0, 0, 2'b11, 0, 0, 0, 0);
    run_txn(0, 32'h0000_7010, 4'hF, 32'h0,        32'h9999AAAA, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    run_txn(0, 32'h0000_7014, 4'hF, 32'h0,        32'hBBBBCCCC, 0, 0, 0, 2'b00, 0, 1, 0, 0);
    run_txn(1, 32'h0000_7018, 4'hF, 32'hDDDDEEEE, 32'h0,        0, 0, 0, 2'b01, 1, 0, 0, 0);
    // Request held high across three reads.
    run_txn(0, 32'h0000_8000, 4'hF, 32'h0,        32'h00000001, 1, 0, 1, 2'b00, 0, 0, 1, 0);
    run_txn(0, 32'h0000_8004, 4'hF, 32'h0,        32'h00000002, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    run_txn(0, 32'h0000_8008, 4'hF, 32'h0,        32'h00000003, 2, 0, 0, 2'b00, 0, 0, 0, 0);

    // Reset while waiting for R: bridge must drop everything and return to idle.
    data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0000_9000;
    #1 check("gnt_pre_rst", data_gnt, 1);
    @(negedge clk);
    data_req = 1'b0; m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
    check("wait_rready", m_axi_rready, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_wait", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready,
                          data_rvalid, data_err}, 0);
    exp_cnt = 0; exp_eaddr = 32'd0;
    check_err_capture();
    run_txn(0, 32'h0000_9004, 4'hF, 32'h0, 32'hFEEDFACE, 0, 0, 0, 2'b00, 0, 0, 0, 3);

    for (int n = 0; n < 50; n++) begin
      logic [1:0] resp;
      resp = 2'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), resp,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
